// File: rtl/store_unit.sv
// Store unit: turns SB/SH/SW requests into lane-positioned word writes; crossing stores split in two beats.
// Latency: accept-to-store_done 2 cycles aligned, 3 split, 1 illegal (mem_ack high).
// Backpressure: in_ready low while a store is outstanding; beats hold until mem_ack.
//
// Ports: in_* request (valid/ready, byte address, rs2 data, store control),
//        mem_* word-wide write bus with byte enables and ack,
//        store_done/store_err one-cycle retire pulse.
// Build option: define STORE_MISALIGN_TRAP_EN to trap misaligned SH/SW instead of splitting.
module store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [2:0]        in_store_control,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              store_done,
    output logic              store_err
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("store_unit: DATA_W must be 32");
    end

    // Store control encodings (RISC-V funct3 for stores).
    localparam logic [2:0] CTRL_SB = 3'b000;
    localparam logic [2:0] CTRL_SH = 3'b001;
    localparam logic [2:0] CTRL_SW = 3'b010;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]          state;
    logic [ADDR_W-1:0]   beat_addr;   // word-aligned address of beat 0
    logic [6:0]          m7_q;
    logic [2*DATA_W-1:0] d64_q;
    logic                err_q;

    // Lane math on the incoming request.
    logic [1:0]          off;
    logic [3:0]          base_mask;
    logic [DATA_W-1:0]   data_mask;
    logic                legal;
    logic                misaligned;
    logic [6:0]          m7;
    logic [2*DATA_W-1:0] d64;
    logic                accept;

    assign off    = in_addr[1:0];
    assign accept = in_valid && in_ready;

    always_comb begin
        base_mask = 4'b0000;
        data_mask = '0;
        legal     = 1'b1;
        case (in_store_control)
            CTRL_SB: begin base_mask = 4'b0001; data_mask = 32'h0000_00FF; end
            CTRL_SH: begin base_mask = 4'b0011; data_mask = 32'h0000_FFFF; end
            CTRL_SW: begin base_mask = 4'b1111; data_mask = 32'hFFFF_FFFF; end
            default: legal = 1'b0;
        endcase
    end

`ifdef STORE_MISALIGN_TRAP_EN
    assign misaligned = ((in_store_control == CTRL_SH) && off[0]) ||
                        ((in_store_control == CTRL_SW) && (off != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Bytes outside the access size are zeroed before shifting so disabled
    // lanes always carry 0 on the bus.
    assign m7  = {3'b000, base_mask} << off;
    assign d64 = {{DATA_W{1'b0}}, in_wdata & data_mask} << {off, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat_addr <= '0;
            m7_q      <= '0;
            d64_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        beat_addr <= {in_addr[ADDR_W-1:2], 2'b00};
                        m7_q      <= m7;
                        d64_q     <= d64;
                        if (!legal || misaligned) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= BEAT0;
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ack) begin
                        state <= (|m7_q[6:4]) ? BEAT1 : RESP;
                    end
                end
                BEAT1: begin
                    if (mem_ack) begin
                        state <= RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so reset drops mem_req immediately.
    always_comb begin
        in_ready   = (state == IDLE);
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = 4'b0000;
        store_done = 1'b0;
        store_err  = 1'b0;
        case (state)
            BEAT0: begin
                mem_req   = 1'b1;
                mem_addr  = beat_addr;
                mem_be    = m7_q[3:0];
                mem_wdata = d64_q[DATA_W-1:0];
            end
            BEAT1: begin
                mem_req   = 1'b1;
                mem_addr  = beat_addr + ADDR_W'(4);   // wraps past the top of memory
                mem_be    = {1'b0, m7_q[6:4]};
                mem_wdata = d64_q[2*DATA_W-1:DATA_W];
            end
            RESP: begin
                store_done = 1'b1;
                store_err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [2:0]  in_store_control = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b1;
    logic        store_done;
    logic        store_err;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    beat_t beat_q[$];

    store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_addr(in_addr),
        .in_wdata(in_wdata),
        .in_store_control(in_store_control),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be(mem_be),
        .mem_ack(mem_ack),
        .store_done(store_done),
        .store_err(store_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        beat_t b;
        b.addr  = a;
        b.be    = be;
        b.wdata = d;
        beat_q.push_back(b);
    endtask

    // Drive one request, compare each acked beat against the scoreboard,
    // then check the retire pulse, its latency and error flag.
    task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] c, input int exp_lat, input logic exp_err);
        bit got = 0;
        beat_t b;
        @(negedge clk);
        in_valid = 1'b1;
        in_addr = a;
        in_wdata = d;
        in_store_control = c;
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (mem_req && mem_ack) begin
                if (beat_q.size() == 0) begin
                    check({tag, "_unexpected_beat"}, 32'd1, 32'd0);
                end else begin
                    b = beat_q.pop_front();
                    check({tag, "_mem_addr"}, mem_addr, b.addr);
                    check({tag, "_mem_be"}, 32'(mem_be), 32'(b.be));
                    check({tag, "_mem_wdata"}, mem_wdata, b.wdata);
                end
            end
            if (store_done) begin
                got = 1;
                check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
                check({tag, "_store_err"}, 32'(store_err), 32'(exp_err));
                check({tag, "_in_ready_resp"}, 32'(in_ready), 32'd0);
                check({tag, "_beats_left"}, 32'(beat_q.size()), 32'd0);
            end
        end
        if (!got) check({tag, "_done_timeout"}, 32'd0, 32'd1);
        beat_q.delete();
        @(negedge clk);
        check({tag, "_done_pulse_width"}, 32'(store_done), 32'd0);
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset values, sampled while reset is held.
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_store_done", 32'(store_done), 32'd0);
        check("rst_store_err", 32'(store_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        push_beat(32'h0000_1000, 4'b1111, 32'hDEAD_BEEF);
        run_store("sw_aligned", 32'h0000_1000, 32'hDEAD_BEEF, SW, 2, 1'b0);

        push_beat(32'h0000_2000, 4'b1000, 32'hA500_0000);
        run_store("sb_off3", 32'h0000_2003, 32'h0000_00A5, SB, 2, 1'b0);

        // Upper bytes of rs2 must not leak into disabled lanes.
        push_beat(32'h0000_2000, 4'b0010, 32'h0000_A500);
        run_store("sb_off1_junk", 32'h0000_2001, 32'h1234_56A5, SB, 2, 1'b0);

        push_beat(32'h0000_4000, 4'b1100, 32'hBEEF_0000);
        run_store("sh_off2", 32'h0000_4002, 32'hCAFE_BEEF, SH, 2, 1'b0);

`ifdef STORE_MISALIGN_TRAP_EN
        run_store("sw_off2_trap", 32'h0000_3002, 32'h1122_3344, SW, 1, 1'b1);
        run_store("sh_wrap_trap", 32'hFFFF_FFFF, 32'h0000_BEEF, SH, 1, 1'b1);
`else
        push_beat(32'h0000_3000, 4'b1100, 32'h3344_0000);
        push_beat(32'h0000_3004, 4'b0011, 32'h0000_1122);
        run_store("sw_off2_split", 32'h0000_3002, 32'h1122_3344, SW, 3, 1'b0);

        push_beat(32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
        push_beat(32'h0000_0000, 4'b0001, 32'h0000_00BE);
        run_store("sh_wrap_split", 32'hFFFF_FFFF, 32'h0000_BEEF, SH, 3, 1'b0);
`endif

        run_store("illegal_111", 32'h0000_6000, 32'h1234_5678, 3'b111, 1, 1'b0 | 1'b1);
        run_store("illegal_011", 32'h0000_6004, 32'h1234_5678, 3'b011, 1, 1'b1);

        // Stall in BEAT0, then reset mid-transaction.
        @(negedge clk);
        mem_ack = 1'b0;
        in_valid = 1'b1;
        in_addr = 32'h0000_5000;
        in_wdata = 32'h0BAD_F00D;
        in_store_control = SW;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("stall_mem_req", 32'(mem_req), 32'd1);
            check("stall_mem_addr", mem_addr, 32'h0000_5000);
            check("stall_mem_be", 32'(mem_be), 32'hF);
            check("stall_mem_wdata", mem_wdata, 32'h0BAD_F00D);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_store_done", 32'(store_done), 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_done", 32'(store_done), 32'd0);
            check("post_rst_no_req", 32'(mem_req), 32'd0);
        end

        push_beat(32'h0000_7000, 4'b0001, 32'h0000_0042);
        run_store("sb_after_rst", 32'h0000_7000, 32'hFFFF_FF42, SB, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Executes stores decoded from S-type instructions: takes effective address, rs2 data and the 3-bit store control (`SB`/`SH`/`SW` from processor_defines.sv), and drives a word-wide data-memory write bus with byte enables.
- Sits between the execute stage (address = rs1 + sign-extended imm) and data memory.
- Misaligned stores that cross a word boundary are split into two bus beats.
- Reports completion or error back to the pipeline with a one-cycle pulse.

Parameters:
- ADDR_W, 32, address width; a word is 4 bytes, so addr[1:0] is the byte offset.
- DATA_W, 32, store data and memory bus width; fixed at 32, any other value is a elaboration error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  store request valid.
- in_ready  output  1  unit can accept a request.
- in_addr  input  ADDR_W  byte effective address.
- in_wdata  input  DATA_W  rs2 value; the low bytes are used per size.
- in_store_control  input  3  `SB`, `SH` or `SW`; any other code is illegal.
- mem_req  output  1  write beat valid.
- mem_addr  output  ADDR_W  word-aligned beat address, addr[1:0] = 0.
- mem_wdata  output  DATA_W  lane-positioned write data.
- mem_be  output  4  byte enables; bit i covers mem_wdata[8i+7:8i].
- mem_ack  input  1  memory accepted the current beat.
- store_done  output  1  one-cycle pulse when the store retires.
- store_err  output  1  valid with store_done; 1 = illegal control code (or misaligned, see feature).

Behaviour:
- Reset: state IDLE; in_ready=1; mem_req=0; mem_addr, mem_wdata, mem_be, store_done and store_err all 0. Reset acts asynchronously mid-transaction: mem_req drops immediately and the store is abandoned, with no done pulse.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - in_ready=1.
  - A request is accepted when in_valid=1 and in_ready=1; it is registered on that edge.
  - A legal control code goes to BEAT0.
  - An illegal code goes to RESP with err=1 and no memory access.
- Lane math, computed at accept time:
  - off = in_addr[1:0].
  - Base mask: `SB`=4'b0001, `SH`=4'b0011, `SW`=4'b1111.
  - m7 = base << off, 7 bits wide.
  - d64 = zero-extended in_wdata << (8*off), 64 bits wide.
  - split = |m7[6:4].
- BEAT0: mem_req=1, mem_addr={in_addr[ADDR_W-1:2],2'b00}, mem_be=m7[3:0], mem_wdata=d64[31:0]. On mem_ack, go to BEAT1 if split, else RESP.
- BEAT1: mem_addr = beat0 address + 4, wrapping modulo 2^ADDR_W; mem_be={1'b0,m7[6:4]}; mem_wdata=d64[63:32]. On mem_ack, go to RESP.
- mem_req and all mem_* outputs hold stable while waiting for mem_ack. mem_ack is sampled only while mem_req=1 and ignored otherwise.
- RESP: store_done=1 for exactly one cycle, store_err as latched, in_ready=0, then IDLE. A new request is accepted the cycle after the done pulse.
- in_ready=0 in BEAT0, BEAT1 and RESP; at most one store is outstanding.
- Latency with mem_ack tied high:
  - Aligned store: accept edge, BEAT0 one cycle, done pulse on the next cycle. That is 2 cycles from accept to store_done.
  - Split store: 3 cycles.
  - Illegal control code: 1 cycle.
- Disabled byte lanes: mem_wdata bytes whose enable is clear are driven 0.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined: a store with a misaligned address (`SH` with off[0]=1, `SW` with off!=0) is not split and makes no bus access. The unit goes IDLE to RESP with store_err=1, the same as an illegal code.
- Undefined: misaligned stores are split or positioned as described in Behaviour, and store_err is 1 only for illegal codes.

Test Plan:
- `SW` addr=0x1000, wdata=0xDEADBEEF, ack tied high: one beat with mem_addr=0x1000, be=4'b1111, wdata=0xDEADBEEF; store_done 2 cycles after accept with err=0.
- `SB` addr=0x2003, wdata=0x000000A5: mem_addr=0x2000, be=4'b1000, wdata=0xA5000000; single beat.
- `SW` addr=0x3002, wdata=0x11223344, feature off: beat0 addr=0x3000, be=4'b1100, wdata=0x33440000; beat1 addr=0x3004, be=4'b0011, wdata=0x00001122; done after the second ack. With the feature on: no mem_req, store_done with err=1.
- `SH` addr=0xFFFFFFFF, wdata=0xBEEF, feature off: beat0 addr=0xFFFFFFFC, be=4'b1000, wdata=0xEF000000; beat1 addr=0x00000000 (wrap), be=4'b0001, wdata=0x000000BE.
- in_store_control=3'b111 (not `SB`/`SH`/`SW`): no mem_req, store_done=1 with store_err=1 one cycle after accept.
- mem_ack held low for 5 cycles during BEAT0, then rst_n pulsed low: mem_* stays stable while waiting. At reset, mem_req goes to 0 immediately, no store_done pulse, and in_ready=1.
